fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the next-PC stage.
- Accepts the registered PC, issues a word read to instruction memory over a req/ack handshake with variable latency, and presents the instruction plus its PC to decode through a valid/stall interface.
- A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.
- Branch flush discards in-flight and buffered work.

Parameters:
- PCLEN, 32, width of PC and instruction-memory address.
- ILEN, 32, instruction width.
- NOP_INST, 32'h00000013, instruction word substituted for a misaligned fetch.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- pcIn  input  PCLEN  PC from the next-PC stage.
- pcValid  input  1  pcIn is stable and should be fetched.
- fetchBusy  output  1  combinational; high when state != IDLE; the next-PC stage holds its PC while high.
- flush  input  1  branch redirect; kill all younger work.
- imemReq  output  1  read request; held until ack.
- imemAddr  output  PCLEN  word address; bits [1:0] always 0.
- imemAck  input  1  one-cycle response strobe; imemData valid with it.
- imemData  input  ILEN  fetched word.
- stall  input  1  decode cannot consume the output this cycle.
- instValid  output  1  instOut/pcInstOut hold a valid instruction.
- instOut  output  ILEN  instruction to decode.
- pcInstOut  output  PCLEN  PC of instOut.
- misalign  output  1  qualifies instOut: fetch PC had [1:0] != 0.
- fetchCount  output  32  instructions delivered to decode, wraps.

Behaviour:
- Reset (async): state=IDLE; imemReq=0; imemAddr=0; instValid=0; instOut=0; pcInstOut=0; misalign=0; skidValid=0; dropPending=0; fetchCount=0.
- Output register "free" = !instValid || !stall.
- Transfer to decode = posedge with instValid && !stall; fetchCount += 1 on each transfer, mod 2^32.
- States: IDLE, REQ, HOLD.
- IDLE, flush=1: no request is issued; flush has priority over pcValid.
- IDLE, pcValid && pcIn[1:0]==0: on the next edge, imemAddr<=pcIn, reqPc<=pcIn, imemReq<=1, go to REQ.
- IDLE, pcValid && pcIn[1:0]!=0 && output free: no memory request. Load instOut<=NOP_INST, pcInstOut<=pcIn, misalign<=1, instValid<=1. Stay in IDLE.
- IDLE, misaligned pcIn with output not free: wait in IDLE.
- REQ: imemReq and imemAddr are held stable until the imemAck edge. A transaction is never abandoned.
- REQ, ack while dropPending=1: discard data, clear dropPending, imemReq<=0, go to IDLE.
- REQ, ack with output free: load instOut<=imemData, pcInstOut<=reqPc, misalign<=0, instValid<=1. imemReq<=0, go to IDLE.
- REQ, ack with output not free: capture into the skid buffer (data, reqPc), set skidValid, imemReq<=0, go to HOLD.
- HOLD: when stall=0, the current output transfers, the skid moves into the output register, skidValid<=0, and the state goes to IDLE. Latency is one edge after stall drops.
- Latency: an aligned PC accepted in IDLE reaches instValid at the edge of the ack, so minimum ack latency gives 2 cycles from the pcValid edge.
- Throughput: at most one outstanding request.
- flush, any state, next edge: instValid<=0, misalign<=0, skidValid<=0.
- flush in HOLD: go to IDLE.
- flush in REQ without simultaneous ack: set dropPending; imemReq stays high until ack.
- flush in REQ with simultaneous ack: data is discarded, go to IDLE.
- Flushed instructions are not counted.
- flush and stall together: flush wins.
- Reset mid-REQ: imemReq falls asynchronously. Memory must tolerate a withdrawn request.
- Addresses use PCLEN-bit arithmetic; no wrap handling is needed because no address is computed here.

Test Plan:
- Reset, then pcValid with pcIn=0x100 and ack 3 cycles after the req edge, imemData=0xDEADBEEF -> imemAddr=0x100 stable for 3 cycles; instValid=1, instOut=0xDEADBEEF, pcInstOut=0x100 at the ack edge; fetchCount=1 after the consuming edge.
- Output holding 0x11111111 with stall=1, new fetch acks 0x22222222 -> state HOLD, output unchanged. stall drops -> next edge output=0x22222222; fetchCount +1 per consumed instruction.
- flush 1 cycle after req issue, ack 2 cycles later -> imemReq high until ack; no instValid; fetchCount unchanged; state IDLE.
- flush coincident with ack, and separately flush in HOLD -> instValid=0, skid discarded, state IDLE, next pcValid=0x200 fetched normally.
- pcIn=0x102 -> imemReq never asserted; instOut=0x00000013, misalign=1, pcInstOut=0x102.
- Assert rst mid-REQ -> imemReq, instValid and fetchCount go to 0 without a clock edge; operation resumes after rst deasserts.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one word read at a time to instruction memory and
// hands the result to decode, with a one-entry skid buffer for responses that land during a stall.
module fetch_unit #(
    parameter int              PCLEN    = 32,
    parameter int              ILEN     = 32,
    parameter logic [ILEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PCLEN-1:0] pcIn,
    input  logic             pcValid,
    output logic             fetchBusy,
    input  logic             flush,
    output logic             imemReq,
    output logic [PCLEN-1:0] imemAddr,
    input  logic             imemAck,
    input  logic [ILEN-1:0]  imemData,
    input  logic             stall,
    output logic             instValid,
    output logic [ILEN-1:0]  instOut,
    output logic [PCLEN-1:0] pcInstOut,
    output logic             misalign,
    output logic [31:0]      fetchCount
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [PCLEN-1:0]  req_pc;
    logic              skid_valid;
    logic [ILEN-1:0]   skid_data;
    logic [PCLEN-1:0]  skid_pc;
    logic              drop_pending;

    logic out_free;
    logic transfer;
    logic aligned;
    logic start_req;
    logic finish_req;
    logic load_mem;
    logic load_nop;
    logic load_skid;
    logic capture_skid;
    logic drop_set;
    logic drop_clr;

    assign out_free  = !instValid || !stall;
    // A flushed instruction never counts as delivered, even if decode was not stalled.
    assign transfer  = instValid && !stall && !flush;
    assign aligned   = (pcIn[1:0] == 2'b00);
    assign fetchBusy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        start_req    = 1'b0;
        finish_req   = 1'b0;
        load_mem     = 1'b0;
        load_nop     = 1'b0;
        load_skid    = 1'b0;
        capture_skid = 1'b0;
        drop_set     = 1'b0;
        drop_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && pcValid) begin
                    if (aligned) begin
                        start_req  = 1'b1;
                        state_next = REQ;
                    end else if (out_free) begin
                        load_nop = 1'b1;
                    end
                end
            end
            REQ: begin
                // The bus transaction always runs to its ack; a flush only marks the data for discard.
                if (imemAck) begin
                    finish_req = 1'b1;
                    state_next = IDLE;
                    if (drop_pending || flush) begin
                        drop_clr = 1'b1;
                    end else if (out_free) begin
                        load_mem = 1'b1;
                    end else begin
                        capture_skid = 1'b1;
                        state_next   = HOLD;
                    end
                end else if (flush) begin
                    drop_set = 1'b1;
                end
            end
            HOLD: begin
                if (flush || !skid_valid) begin
                    state_next = IDLE;
                end else if (!stall) begin
                    load_skid  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imemReq      <= 1'b0;
            imemAddr     <= '0;
            req_pc       <= '0;
            drop_pending <= 1'b0;
        end else begin
            if (start_req) begin
                imemReq  <= 1'b1;
                imemAddr <= pcIn;
                req_pc   <= pcIn;
            end else if (finish_req) begin
                imemReq <= 1'b0;
            end
            if (drop_set) begin
                drop_pending <= 1'b1;
            end else if (drop_clr) begin
                drop_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instValid <= 1'b0;
            instOut   <= '0;
            pcInstOut <= '0;
            misalign  <= 1'b0;
        end else if (flush) begin
            instValid <= 1'b0;
            misalign  <= 1'b0;
        end else if (load_mem) begin
            instValid <= 1'b1;
            instOut   <= imemData;
            pcInstOut <= req_pc;
            misalign  <= 1'b0;
        end else if (load_nop) begin
            instValid <= 1'b1;
            instOut   <= NOP_INST;
            pcInstOut <= pcIn;
            misalign  <= 1'b1;
        end else if (load_skid) begin
            instValid <= 1'b1;
            instOut   <= skid_data;
            pcInstOut <= skid_pc;
            misalign  <= 1'b0;
        end else if (transfer) begin
            instValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (capture_skid) begin
            skid_valid <= 1'b1;
            skid_data  <= imemData;
            skid_pc    <= req_pc;
        end else if (load_skid) begin
            skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchCount <= '0;
        end else if (transfer) begin
            fetchCount <= fetchCount + 32'd1;
        end
    end

endmodule
